// File: rtl/lutram_test_pkg.sv
// Shared types and constants for the LUTRAM readback checker and its stimulus side.
package lutram_test_pkg;

    localparam int A_WIDTH_DEF = 7;

    localparam int EXP_ZERO  = 0;
    localparam int EXP_ALT   = 1;
    localparam int EXP_ALT_N = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } chk_state_e;

    // Unknown modes (3) fall back to the cleared-RAM pattern.
    function automatic logic exp_bit(input int mode, input logic addr_lsb);
        case (mode)
            EXP_ALT:   return addr_lsb;
            EXP_ALT_N: return ~addr_lsb;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lutram_readback_checker_if.sv
// Control/status bundle between the readback checker (slave) and its driver (master).
interface lutram_readback_checker_if #(
    parameter int A_WIDTH   = 7,
    parameter int CNT_WIDTH = 8
) ();

    logic                 start_i;
    logic                 en_i;
    logic                 q_i;
    logic [A_WIDTH-1:0]   addr_o;
    logic                 busy_o;
    logic                 done_o;
    logic                 pass_o;
    logic [CNT_WIDTH-1:0] err_cnt_o;
    logic [A_WIDTH-1:0]   first_err_addr_o;

    modport master (
        output start_i, en_i, q_i,
        input  addr_o, busy_o, done_o, pass_o, err_cnt_o, first_err_addr_o
    );

    modport slave (
        input  start_i, en_i, q_i,
        output addr_o, busy_o, done_o, pass_o, err_cnt_o, first_err_addr_o
    );

endinterface

// File: rtl/lutram_exp_gen.sv
// Expected-bit generator shared by the write stimulus and the readback checker.
module lutram_exp_gen
    import lutram_test_pkg::*;
#(
    parameter int A_WIDTH  = A_WIDTH_DEF,
    parameter int EXP_MODE = EXP_ALT
) (
    input  logic [A_WIDTH-1:0] addr_i,
    output logic               exp_o
);

    // Only the LSB selects the pattern; the upper bits are deliberately ignored.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr_i;

    assign exp_o = exp_bit(EXP_MODE, addr_i[0]);

endmodule

// File: rtl/lutram_readback_checker.sv
// Read-side LUTRAM checker: walks every address once per pass and counts mismatches.
// Optional first-failing-address capture is built when LUTRAM_CHK_FIRST_ERR_EN is defined.
module lutram_readback_checker
    import lutram_test_pkg::*;
#(
    parameter int A_WIDTH   = A_WIDTH_DEF,
    parameter int EXP_MODE  = EXP_ALT,
    parameter int CNT_WIDTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    lutram_readback_checker_if.slave   bus
);

    localparam logic [A_WIDTH-1:0]   ADDR_LAST = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

    chk_state_e           state_q, state_d;
    logic [A_WIDTH-1:0]   addr_q, addr_d;
    logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 pass_q, pass_d;

    logic exp_w;
    logic sample;
    logic mismatch;
    logic start_accept;

    lutram_exp_gen #(
        .A_WIDTH  (A_WIDTH),
        .EXP_MODE (EXP_MODE)
    ) u_exp_gen (
        .addr_i (addr_q),
        .exp_o  (exp_w)
    );

    // A start during CHECK is ignored; en_i only counts while checking.
    assign start_accept = bus.start_i && (state_q != CHECK);
    assign sample       = bus.en_i && (state_q == CHECK);
    assign mismatch     = sample && (bus.q_i != exp_w);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        err_cnt_d = err_cnt_q;
        busy_d    = busy_q;
        done_d    = done_q;
        pass_d    = pass_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_accept) begin
                    state_d   = CHECK;
                    addr_d    = '0;
                    err_cnt_d = '0;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                end
            end
            CHECK: begin
                if (sample) begin
                    addr_d = addr_q + 1'b1;
                    if (mismatch && (err_cnt_q != CNT_MAX)) begin
                        err_cnt_d = err_cnt_q + 1'b1;
                    end
                    if (addr_q == ADDR_LAST) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_cnt_d == '0);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
                pass_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            err_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            err_cnt_q <= err_cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
        end
    end

`ifdef LUTRAM_CHK_FIRST_ERR_EN
    logic [A_WIDTH-1:0] first_err_q, first_err_d;

    // A zero error count means no mismatch has been seen yet this pass.
    always_comb begin
        first_err_d = first_err_q;
        if (start_accept) begin
            first_err_d = '0;
        end else if (mismatch && (err_cnt_q == '0)) begin
            first_err_d = addr_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            first_err_q <= '0;
        end else begin
            first_err_q <= first_err_d;
        end
    end

    assign bus.first_err_addr_o = first_err_q;
`else
    assign bus.first_err_addr_o = '0;
`endif

    assign bus.addr_o    = addr_q;
    assign bus.busy_o    = busy_q;
    assign bus.done_o    = done_q;
    assign bus.pass_o    = pass_q;
    assign bus.err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_lutram_readback_checker.sv
// Self-checking bench for lutram_readback_checker; honours LUTRAM_CHK_FIRST_ERR_EN.
module tb_lutram_readback_checker;

    localparam int AW    = 7;
    localparam int N     = 128;
    localparam int MAX8  = 255;
    localparam int MAX4  = 15;

    logic clk;
    logic rst_n;

    int n_cmp;
    int n_fail;

    bit flip [N];

    lutram_readback_checker_if #(.A_WIDTH(AW), .CNT_WIDTH(8)) bus ();
    lutram_readback_checker_if #(.A_WIDTH(AW), .CNT_WIDTH(4)) zbus ();

    lutram_readback_checker #(
        .A_WIDTH   (AW),
        .EXP_MODE  (1),
        .CNT_WIDTH (8)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
    );

    lutram_readback_checker #(
        .A_WIDTH   (AW),
        .EXP_MODE  (0),
        .CNT_WIDTH (4)
    ) dut_z (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (zbus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM models: the first holds the addr[0] pattern with optional corrupted cells,
    // the second reads back constant 1.
    always_comb bus.q_i = bus.addr_o[0] ^ flip[bus.addr_o];
    assign zbus.q_i = 1'b1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int first_expect(input int first_idx);
`ifdef LUTRAM_CHK_FIRST_ERR_EN
        return (first_idx < 0) ? 0 : first_idx;
`else
        return 0;
`endif
    endfunction

    task automatic run_pass(input int gap_min, input int gap_max, input bit start_with_en,
                            input int abort_at, input int mid_start_at);
        int exp_cnt;
        int exp_first;
        int cycles;
        int gap;
        exp_cnt   = 0;
        exp_first = -1;
        cycles    = 0;

        bus.start_i = 1'b1;
        bus.en_i    = start_with_en;
        tick();
        cycles++;
        bus.start_i = 1'b0;
        bus.en_i    = 1'b0;
        check("start_busy", bus.busy_o, 1);
        check("start_done", bus.done_o, 0);
        check("start_cnt", bus.err_cnt_o, 0);
        check("start_addr", bus.addr_o, 0);
        check("start_first", bus.first_err_addr_o, 0);

        for (int a = 0; a < N; a++) begin
            if (a == abort_at) begin
                check("pre_abort_addr", bus.addr_o, a);
                rst_n = 1'b0;
                #1;
                check("abort_addr", bus.addr_o, 0);
                check("abort_busy", bus.busy_o, 0);
                check("abort_done", bus.done_o, 0);
                check("abort_pass", bus.pass_o, 0);
                check("abort_cnt", bus.err_cnt_o, 0);
                check("abort_first", bus.first_err_addr_o, 0);
                #2;
                rst_n = 1'b1;
                tick();
                check("post_abort_done", bus.done_o, 0);
                check("post_abort_busy", bus.busy_o, 0);
                return;
            end
            check("addr", bus.addr_o, a);
            if (flip[a]) begin
                if (exp_cnt < MAX8) exp_cnt++;
                if (exp_first < 0) exp_first = a;
            end
            bus.en_i = 1'b1;
            if (a == mid_start_at) bus.start_i = 1'b1;
            tick();
            cycles++;
            bus.en_i    = 1'b0;
            bus.start_i = 1'b0;
            check("err_cnt", bus.err_cnt_o, exp_cnt);
            if (a < N - 1) begin
                check("mid_busy", bus.busy_o, 1);
                check("mid_done", bus.done_o, 0);
                gap = $urandom_range(gap_max, gap_min);
                repeat (gap) begin
                    tick();
                    cycles++;
                end
            end
        end

        check("end_done", bus.done_o, 1);
        check("end_busy", bus.busy_o, 0);
        check("end_pass", bus.pass_o, (exp_cnt == 0) ? 1 : 0);
        check("end_cnt", bus.err_cnt_o, exp_cnt);
        check("end_addr", bus.addr_o, 0);
        check("end_first", bus.first_err_addr_o, first_expect(exp_first));
        if (gap_max == 0) check("pass_len", cycles, N + 1);

        // done/pass must hold while idle in DONE, and stray strobes do nothing
        bus.en_i = 1'b1;
        tick();
        tick();
        bus.en_i = 1'b0;
        check("hold_done", bus.done_o, 1);
        check("hold_addr", bus.addr_o, 0);
        check("hold_cnt", bus.err_cnt_o, exp_cnt);
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        bus.start_i  = 1'b0;
        bus.en_i     = 1'b0;
        zbus.start_i = 1'b0;
        zbus.en_i    = 1'b0;
        for (int i = 0; i < N; i++) flip[i] = 1'b0;

        #1;
        check("rst_addr", bus.addr_o, 0);
        check("rst_busy", bus.busy_o, 0);
        check("rst_done", bus.done_o, 0);
        check("rst_pass", bus.pass_o, 0);
        check("rst_cnt", bus.err_cnt_o, 0);
        check("rst_first", bus.first_err_addr_o, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // strobes in IDLE are ignored
        bus.en_i = 1'b1;
        repeat (3) tick();
        bus.en_i = 1'b0;
        check("idle_en_addr", bus.addr_o, 0);
        check("idle_en_busy", bus.busy_o, 0);
        check("idle_en_done", bus.done_o, 0);

        // clean back-to-back pass
        run_pass(0, 0, 1'b0, -1, -1);

        // corrupted cells at 5 and 77
        flip[5]  = 1'b1;
        flip[77] = 1'b1;
        run_pass(0, 0, 1'b0, -1, -1);

        // rerun from DONE-with-errors: start+en together, gaps of 3, start mid-pass
        for (int i = 0; i < N; i++) flip[i] = 1'b0;
        run_pass(3, 3, 1'b1, -1, 40);

        // randomized corruption and strobe spacing
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N; i++) flip[i] = ($urandom_range(15, 0) == 0);
            run_pass(0, 2, 1'b0, -1, -1);
        end

        // reset at address 60, then a clean pass
        for (int i = 0; i < N; i++) flip[i] = ($urandom_range(3, 0) == 0);
        flip[10] = 1'b1;
        run_pass(0, 1, 1'b0, 60, -1);
        for (int i = 0; i < N; i++) flip[i] = 1'b0;
        run_pass(0, 0, 1'b0, -1, -1);

        // saturating counter: zero pattern expected, RAM reads all ones
        zbus.start_i = 1'b1;
        tick();
        zbus.start_i = 1'b0;
        check("sat_busy", zbus.busy_o, 1);
        zbus.en_i = 1'b1;
        for (int a = 0; a < N; a++) begin
            tick();
            check("sat_cnt", zbus.err_cnt_o, (a + 1 < MAX4) ? a + 1 : MAX4);
        end
        zbus.en_i = 1'b0;
        check("sat_done", zbus.done_o, 1);
        check("sat_pass", zbus.pass_o, 0);
        check("sat_first", zbus.first_err_addr_o, 0);
        check("sat_addr", zbus.addr_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
